// File: rtl/lsu_mmio.sv
// rtl/lsu_mmio.sv - MEM-stage load/store unit: data RAM, output register bank, synchronized switch inputs
module lsu_mmio #(
  parameter int          DMEM_WORDS = 256,
  parameter int          N_OUT      = 11,
  parameter int          IN_W       = 17,
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0800,
  parameter logic [31:0] OUT_BASE   = 32'h0000_0C00,
  parameter logic [31:0] IN_BASE    = 32'h0000_0D00
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [2:0]           funct3_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic                 ready_o,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  output logic                 err_o,
  input  logic [IN_W-1:0]      io_sw_i,
  output logic [N_OUT*32-1:0]  io_out_o
);

  localparam int          DW       = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int          OW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [31:0] DMEM_END = DMEM_BASE + 32'(4 * DMEM_WORDS);
  localparam logic [31:0] OUT_END  = OUT_BASE + 32'(4 * N_OUT);
  localparam logic [31:0] IN_END   = IN_BASE + 32'd256;

  // Source of the registered load word; ZERO also covers faulted loads and reset.
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_PER  = 2'd2;

  typedef enum logic {S_IDLE, S_RESP} state_t;
  state_t state_q, state_d;

  logic [31:0]    mem [DMEM_WORDS];
  logic [31:0]    out_q [N_OUT];
  logic [IN_W-1:0] sw_meta, sw_sync;

  logic [31:0] dmem_off, out_off, in_off;
  logic        hit_dmem, hit_out, hit_in;
  logic        legal_f3, misalign, fault;
  logic        accept, ld_acc, st_ok;
  logic [3:0]  be;
  logic [31:0] wlane, per_word;
  logic [DW-1:0] dmem_idx;
  logic [OW-1:0] out_idx;

  logic        err_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q, src_q;
  logic [31:0] ram_rdata_q, per_rdata_q;
  logic [31:0] word, shifted;

  assign dmem_off = addr_i - DMEM_BASE;
  assign out_off  = addr_i - OUT_BASE;
  assign in_off   = addr_i - IN_BASE;
  assign hit_dmem = (addr_i >= DMEM_BASE) && (addr_i < DMEM_END);
  assign hit_out  = (addr_i >= OUT_BASE) && (addr_i < OUT_END);
  assign hit_in   = (addr_i >= IN_BASE) && (addr_i < IN_END);
  assign dmem_idx = dmem_off[DW+1:2];
  assign out_idx  = out_off[OW+1:2];

  // Offset bits outside the word index are covered by the range and alignment checks.
  logic unused_off;
  assign unused_off = ^{dmem_off[31:DW+2], dmem_off[1:0], out_off[31:OW+2], out_off[1:0],
                        in_off[31:8], in_off[1:0]};

  // Size/sign legality, alignment, byte enables and lane-replicated store data.
  always_comb begin
    legal_f3 = 1'b0;
    misalign = 1'b0;
    be       = 4'b0000;
    wlane    = wdata_i;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
      3'b100, 3'b101:         legal_f3 = !we_i;
      default:                legal_f3 = 1'b0;
    endcase
    case (funct3_i[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_i[1:0];
        wlane = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be       = addr_i[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata_i[15:0]}};
        misalign = addr_i[0];
      end
      default: begin
        be       = 4'b1111;
        misalign = (addr_i[1:0] != 2'b00);
      end
    endcase
  end

  assign fault  = !(hit_dmem || hit_out || hit_in) || !legal_f3 || misalign || (we_i && hit_in);
  assign accept = req_i && ready_o;
  assign ld_acc = accept && !we_i;
  assign st_ok  = accept && we_i && !fault;

  // Word a peripheral load would return this cycle; only input word 0 carries the switches.
  always_comb begin
    per_word = 32'd0;
    if (hit_out)                          per_word = out_q[out_idx];
    else if (hit_in && in_off[7:2] == 6'd0) per_word = 32'(sw_sync);
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and handshake outputs; stores never leave IDLE.
  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    rvalid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (req_i && !we_i) state_d = S_RESP;
      end
      S_RESP: begin
        rvalid_o = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture load controls at accept; err pulses the cycle after any faulting accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q       <= 1'b0;
      f3_q        <= 3'b010;
      lane_q      <= 2'b00;
      src_q       <= SRC_ZERO;
      per_rdata_q <= 32'd0;
    end else begin
      err_q <= accept && fault;
      if (ld_acc) begin
        f3_q        <= funct3_i;
        lane_q      <= addr_i[1:0];
        src_q       <= fault ? SRC_ZERO : (hit_dmem ? SRC_RAM : SRC_PER);
        per_rdata_q <= per_word;
      end
    end
  end

  // Synchronous data RAM with byte-lane writes; read port registers only on a load accept.
  always_ff @(posedge clk_i) begin
    if (st_ok && hit_dmem) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[dmem_idx][8*b +: 8] <= wlane[8*b +: 8];
    end
    if (ld_acc && hit_dmem) ram_rdata_q <= mem[dmem_idx];
  end

  // Output peripheral registers, written with the same byte enables as the RAM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= 32'd0;
    end else if (st_ok && hit_out) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) out_q[out_idx][8*b +: 8] <= wlane[8*b +: 8];
    end
  end

  // Two-flop synchronizer for the asynchronous switch bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= io_sw_i;
      sw_sync <= sw_meta;
    end
  end

  // Lane select and extension from held registers, so rdata_o holds between responses.
  always_comb begin
    case (src_q)
      SRC_RAM: word = ram_rdata_q;
      SRC_PER: word = per_rdata_q;
      default: word = 32'd0;
    endcase
    shifted = word >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  rdata_o = {24'd0, shifted[7:0]};
      3'b101:  rdata_o = {16'd0, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

  assign err_o = err_q;

  // Flatten the output bank onto the board-facing bus.
  always_comb begin
    io_out_o = '0;
    for (int k = 0; k < N_OUT; k++) io_out_o[32*k +: 32] = out_q[k];
  end

endmodule

// File: tb/tb_lsu_mmio.sv
// tb/tb_lsu_mmio.sv - scoreboard bench for lsu_mmio
module tb_lsu_mmio;
  logic         clk_i = 1'b0;
  logic         rst_i, req_i, we_i;
  logic [2:0]   funct3_i;
  logic [31:0]  addr_i, wdata_i;
  logic         ready_o, rvalid_o, err_o;
  logic [31:0]  rdata_o;
  logic [16:0]  io_sw_i;
  logic [351:0] io_out_o;

  lsu_mmio dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .io_sw_i(io_sw_i), .io_out_o(io_out_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t ld_q[$];
  logic st_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  bit   pend_ld = 1'b0;
  bit   pend_st = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(posedge clk_i) begin
    pend_ld = mon_en && !rst_i && req_i && ready_o && !we_i;
    pend_st = mon_en && !rst_i && req_i && ready_o && we_i;
  end

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (pend_ld) begin
        check("load_latency_rvalid", 32'(rvalid_o), 32'd1);
        check("resp_ready_low", 32'(ready_o), 32'd0);
      end
      if (rvalid_o) begin
        if (ld_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rvalid: got rdata %h with no load outstanding", rdata_o);
        end else begin
          exp_t e;
          e = ld_q.pop_front();
          check("load_rdata", rdata_o, e.rdata);
          check("load_err", 32'(err_o), 32'(e.err));
        end
      end else if (pend_st && st_q.size() != 0) begin
        logic ee;
        ee = st_q.pop_front();
        check("store_err", 32'(err_o), 32'(ee));
      end else begin
        check("idle_err_low", 32'(err_o), 32'd0);
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    int n = 0;
    exp_t e;
    while (!ready_o && n < 8) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!ready_o) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: ready_o %b after %0d cycles, required 1", ready_o, n);
      return;
    end
    we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
    if (we) st_q.push_back(exp_err);
    else begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      ld_q.push_back(e);
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic e);
    issue(1'b1, f3, a, wd, 32'd0, e);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r, input logic e);
    issue(1'b0, f3, a, 32'd0, r, e);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'd0; wdata_i = 32'd0; io_sw_i = 17'd0;
    #2;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_rvalid", 32'(rvalid_o), 32'd0);
    check("reset_rdata", rdata_o, 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    check("reset_io_out", 32'(io_out_o != '0), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset while a load is in RESP
    st(3'b010, 32'h0000_0C08, 32'hCAFE_F00D, 1'b0);
    check("out2_written", io_out_o[95:64], 32'hCAFE_F00D);
    ld(3'b010, 32'h0000_0800, 32'd0, 1'b0);
    rst_i = 1'b1;
    #1;
    check("rst_resp_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_resp_ready", 32'(ready_o), 32'd1);
    check("rst_resp_io_out", 32'(io_out_o != '0), 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("no_rvalid_after_rst", 32'(rvalid_o), 32'd0);
    end
    ld_q.delete();
    st_q.delete();
    @(posedge clk_i); #1;
    mon_en = 1'b1;

    // Extension and lane selection
    st(3'b010, 32'h0000_0800, 32'h8899_AABB, 1'b0);
    ld(3'b000, 32'h0000_0800, 32'hFFFF_FFBB, 1'b0);
    ld(3'b100, 32'h0000_0800, 32'h0000_00BB, 1'b0);
    ld(3'b001, 32'h0000_0800, 32'hFFFF_AABB, 1'b0);
    ld(3'b101, 32'h0000_0802, 32'h0000_8899, 1'b0);
    ld(3'b000, 32'h0000_0802, 32'hFFFF_FF99, 1'b0);
    ld(3'b001, 32'h0000_0802, 32'hFFFF_8899, 1'b0);
    ld(3'b100, 32'h0000_0803, 32'h0000_0088, 1'b0);
    ld(3'b010, 32'h0000_0800, 32'h8899_AABB, 1'b0);

    // Output bank byte/halfword stores, readable back
    st(3'b010, 32'h0000_0C00, 32'h0000_0000, 1'b0);
    st(3'b000, 32'h0000_0C01, 32'h0000_0055, 1'b0);
    check("out0_after_sb", io_out_o[31:0], 32'h0000_5500);
    ld(3'b010, 32'h0000_0C00, 32'h0000_5500, 1'b0);
    st(3'b001, 32'h0000_0C2A, 32'h1234_BEEF, 1'b0);
    check("out10_after_sh", io_out_o[351:320], 32'hBEEF_0000);
    ld(3'b101, 32'h0000_0C2A, 32'h0000_BEEF, 1'b0);
    ld(3'b010, 32'h0000_0C2C, 32'd0, 1'b1);

    // RAM upper boundary
    st(3'b010, 32'h0000_0BFC, 32'h0BAD_CAFE, 1'b0);
    ld(3'b010, 32'h0000_0BFC, 32'h0BAD_CAFE, 1'b0);

    // Switch inputs through the synchronizer
    io_sw_i = 17'h1ABCD;
    repeat (3) @(posedge clk_i);
    #1;
    ld(3'b010, 32'h0000_0D00, 32'h0001_ABCD, 1'b0);
    ld(3'b010, 32'h0000_0D04, 32'h0000_0000, 1'b0);
    ld(3'b000, 32'h0000_0D00, 32'hFFFF_FFCD, 1'b0);
    ld(3'b010, 32'h0000_0DFC, 32'h0000_0000, 1'b0);
    ld(3'b010, 32'h0000_0E00, 32'd0, 1'b1);

    // Faults
    ld(3'b001, 32'h0000_0801, 32'd0, 1'b1);
    st(3'b010, 32'h0000_0D00, 32'hFFFF_FFFF, 1'b1);
    ld(3'b010, 32'h0000_0D00, 32'h0001_ABCD, 1'b0);
    ld(3'b010, 32'h0000_0000, 32'd0, 1'b1);
    ld(3'b011, 32'h0000_0800, 32'd0, 1'b1);
    st(3'b100, 32'h0000_0800, 32'd0, 1'b1);
    st(3'b010, 32'h0000_0802, 32'd0, 1'b1);
    st(3'b001, 32'h0000_0C05, 32'hFFFF_FFFF, 1'b1);
    check("out1_untouched", io_out_o[63:32], 32'd0);
    ld(3'b010, 32'h0000_0800, 32'h8899_AABB, 1'b0);

    // Back-to-back store then load on consecutive edges
    st(3'b010, 32'h0000_0804, 32'h1122_3344, 1'b0);
    ld(3'b010, 32'h0000_0804, 32'h1122_3344, 1'b0);
    st(3'b000, 32'h0000_0805, 32'h0000_00EE, 1'b0);
    ld(3'b010, 32'h0000_0804, 32'h1122_EE44, 1'b0);

    // Request held high through RESP must be ignored
    ld(3'b010, 32'h0000_0C00, 32'h0000_5500, 1'b0);
    we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0C04; wdata_i = 32'hDEAD_BEEF; req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    check("held_req_ignored", io_out_o[63:32], 32'd0);

    repeat (4) @(posedge clk_i);
    #1;
    check("ld_queue_drained", 32'(ld_q.size()), 32'd0);
    check("st_queue_drained", 32'(st_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
